io_output_seq: RTL and testbench

- Sequences the output statement for the I/O electronic unit: on an output order it walks one word out of AC, character by character, to the output device.
- Order of characters: sign, then N digits obtained by repeated AC shifts (order_io / ac_answer), then an end character.
- After the end character it either resumes the program with a start pulse to pu or stops, per the panel switch.
- Sits beside the input machine in the I/O unit; its order_io and start pulses are ORed there with the input-side sources.

---
 rtl/io_pkg.sv | 35 +++
 rtl/io_output_seq_if.sv | 9 +
 rtl/io_hs4_tx.sv | 34 +++
 rtl/io_output_seq.sv | 118 +++++++++++
 tb/tb_io_output_seq.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// io_pkg: character codes, state and phase encodings shared by the I/O unit.
package io_pkg;
    localparam int OCT_DIGITS_DEF = 10;
    localparam int DEC_DIGITS_DEF = 9;
    localparam int CNT_W_DEF      = 4;

    localparam logic [4:0] SIGN_POS  = 5'b00010;
    localparam logic [4:0] SIGN_NEG  = 5'b00011;
    localparam logic [4:0] END_CODE  = 5'b00111;
    localparam logic [4:0] DIGIT_TAG = 5'b10000;

    localparam int S_IDLE       = 0;
    localparam int S_CHR_REQ    = 1;
    localparam int S_CHR_ACK_LO = 2;
    localparam int S_SHIFT      = 3;
    localparam int S_FINISH     = 4;

    typedef enum logic [4:0] {
        IDLE       = 5'(1 << S_IDLE),
        CHR_REQ    = 5'(1 << S_CHR_REQ),
        CHR_ACK_LO = 5'(1 << S_CHR_ACK_LO),
        SHIFT      = 5'(1 << S_SHIFT),
        FINISH     = 5'(1 << S_FINISH)
    } state_e;

    typedef enum logic [1:0] {
        PH_SIGN  = 2'd0,
        PH_DIGIT = 2'd1,
        PH_END   = 2'd2
    } phase_e;

    function automatic logic [4:0] digit_chr(input logic dec, input logic [3:0] d);
        return DIGIT_TAG | {1'b0, dec ? d : {1'b0, d[2:0]}};
    endfunction
endpackage

// File: rtl/io_output_seq_if.sv
// io_output_seq_if: character output link to the device, 4-phase vld/ack.
interface io_output_seq_if;
    logic       output_vld_to_dev;
    logic [4:0] output_data_to_dev;
    logic       output_ack_from_dev;

    modport master(output output_vld_to_dev, output output_data_to_dev, input output_ack_from_dev);
    modport slave(input output_vld_to_dev, input output_data_to_dev, output output_ack_from_dev);
endinterface

// File: rtl/io_hs4_tx.sv
// io_hs4_tx: 4-phase transmit side; holds data from load until the next load.
module io_hs4_tx #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ack_i,
    output logic         vld_o,
    output logic [W-1:0] data_o
);
    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        vld_d  = clr_i ? 1'b0 : load_i ? 1'b1 : (vld_q & ack_i) ? 1'b0 : vld_q;
        data_d = (load_i & ~clr_i) ? data_i : data_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
endmodule

// File: rtl/io_output_seq.sv
// io_output_seq: walks one AC word out to the output device as sign, N digits, end,
// then resumes the program or reports a stop.
module io_output_seq
    import io_pkg::*;
#(
    parameter int OCT_DIGITS = OCT_DIGITS_DEF,
    parameter int DEC_DIGITS = DEC_DIGITS_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       order_output_from_op,
    input  logic       output_oct_from_pnl,
    input  logic       output_dec_from_pnl,
    input  logic       stop_after_output_from_pnl,
    input  logic       abort_from_pnl,
    input  logic       ac_answer_from_ac,
    input  logic       output_sign_from_ac,
    input  logic [3:0] output_data_from_au,
    output logic       output_active,
    output logic       dec_mode,
    output logic       order_io_to_ac,
    output logic       start_pulse_to_pu,
    output logic       stopped_to_pnl,
    io_output_seq_if.master dev
);
    state_e             state_q, state_d;
    phase_e             phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dec_q, dec_d;
    logic               io_q, io_d;
    logic               load;
    logic [4:0]         chr;
    logic               ack, fin;

    assign ack = dev.output_ack_from_dev;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        io_d    = 1'b0;
        load    = 1'b0;
        chr     = END_CODE;
        case (state_q)
            IDLE: if (order_output_from_op) begin
                dec_d   = output_dec_from_pnl & ~output_oct_from_pnl;
                cnt_d   = dec_d ? CNT_W'(DEC_DIGITS) : CNT_W'(OCT_DIGITS);
                phase_d = PH_SIGN;
                chr     = output_sign_from_ac ? SIGN_NEG : SIGN_POS;
                load    = 1'b1;
                state_d = CHR_REQ;
            end
            CHR_REQ: if (ack) state_d = CHR_ACK_LO;
            CHR_ACK_LO: if (!ack) begin
                if (phase_q == PH_END) state_d = FINISH;
                else if (phase_q == PH_DIGIT && cnt_q == '0) begin
                    load    = 1'b1;
                    phase_d = PH_END;
                    state_d = CHR_REQ;
                end else begin
                    io_d    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: if (ac_answer_from_ac) begin
                chr     = digit_chr(dec_q, output_data_from_au);
                load    = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                phase_d = PH_DIGIT;
                state_d = CHR_REQ;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort outranks everything, including a same-cycle order
        if (abort_from_pnl) begin
            state_d = IDLE;
            io_d    = 1'b0;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            phase_q <= PH_SIGN;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            io_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            io_q    <= io_d;
        end
    end

    io_hs4_tx #(.W(5)) u_tx (
        .clk    (clk),
        .resetn (resetn),
        .clr_i  (abort_from_pnl),
        .load_i (load),
        .data_i (chr),
        .ack_i  (ack),
        .vld_o  (dev.output_vld_to_dev),
        .data_o (dev.output_data_to_dev)
    );

    assign fin               = (state_q == FINISH) & ~abort_from_pnl & resetn;
    assign output_active     = state_q != IDLE;
    assign dec_mode          = dec_q;
    assign order_io_to_ac    = io_q;
    assign start_pulse_to_pu = fin & ~stop_after_output_from_pnl;
    assign stopped_to_pnl    = fin & stop_after_output_from_pnl;
endmodule

// File: tb/tb_io_output_seq.sv
// tb_io_output_seq: device and AC responders plus a character-stream model built
// from the word's sign, mode and AU digits; one negedge process compares.
module tb_io_output_seq;
    logic       clk = 1'b0, resetn = 1'b0;
    logic       order = 1'b0, oct = 1'b0, dec = 1'b0, stp = 1'b0, abort = 1'b0;
    logic       ac_ans = 1'b0, sign = 1'b0;
    logic [3:0] au = 4'h0;
    logic       active, dmode, order_io, start, stopped;

    io_output_seq_if dev();

    io_output_seq dut (
        .clk                        (clk),
        .resetn                     (resetn),
        .order_output_from_op       (order),
        .output_oct_from_pnl        (oct),
        .output_dec_from_pnl        (dec),
        .stop_after_output_from_pnl (stp),
        .abort_from_pnl             (abort),
        .ac_answer_from_ac          (ac_ans),
        .output_sign_from_ac        (sign),
        .output_data_from_au        (au),
        .output_active              (active),
        .dec_mode                   (dmode),
        .order_io_to_ac             (order_io),
        .start_pulse_to_pu          (start),
        .stopped_to_pnl             (stopped),
        .dev                        (dev)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    logic [4:0] expq[$];
    logic [4:0] got[$];
    int io_cnt = 0, start_cnt = 0, stop_cnt = 0, vld_rise = 0, wbase = 0;
    bit exp_dec = 0, shifting = 0, spur_pend = 0, prev_vld = 0;
    logic [4:0] last_data = 5'h0;
    logic [3:0] digs [16];
    int didx = 0, ack_lat = 2, ac_lat = 1, cd = 0, wc = 0;
    logic [3:0] oct_tab [16] = '{4'hf, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] dec_tab [16] = '{4'h9, 4'h8, 4'h1, 4'h0, 4'h5, 4'h3, 4'h7, 4'h2, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

    task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
        n_chk++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, g, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (dev.output_vld_to_dev && !prev_vld) begin
                vld_rise++;
                got.push_back(dev.output_data_to_dev);
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_char: got %0h expected none", dev.output_data_to_dev);
                end else chk("char", dev.output_data_to_dev, expq.pop_front());
            end
            if (dev.output_vld_to_dev && prev_vld) chk("data_hold", dev.output_data_to_dev, last_data);
            if (shifting) chk("vld_in_shift", dev.output_vld_to_dev, 0);
            if (active) chk("dec_mode", dmode, exp_dec);
            if (order_io) io_cnt++;
            if (start) start_cnt++;
            if (stopped) stop_cnt++;
        end
        prev_vld  = dev.output_vld_to_dev;
        last_data = dev.output_data_to_dev;
    end

    initial begin
        dev.output_ack_from_dev = 1'b0;
        forever begin
            @(negedge clk);
            if (dev.output_vld_to_dev && !dev.output_ack_from_dev) begin
                wc++;
                if (wc >= ack_lat) dev.output_ack_from_dev = 1'b1;
            end else if (!dev.output_vld_to_dev) begin
                dev.output_ack_from_dev = 1'b0;
                wc = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        ac_ans = 1'b0;
        if (!active) begin
            cd = 0;
            shifting = 0;
        end
        if (spur_pend && dev.output_vld_to_dev) begin
            ac_ans = 1'b1;
            au = 4'ha;
            spur_pend = 0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                ac_ans = 1'b1;
                au = digs[didx];
                didx++;
                shifting = 0;
            end
        end
        if (order_io) begin
            cd = ac_lat;
            shifting = 1;
        end
    end

    task automatic outs_zero(input string nm);
        chk({nm, "_active"}, active, 0);
        chk({nm, "_dec_mode"}, dmode, 0);
        chk({nm, "_order_io"}, order_io, 0);
        chk({nm, "_start"}, start, 0);
        chk({nm, "_stopped"}, stopped, 0);
        chk({nm, "_vld"}, dev.output_vld_to_dev, 0);
        chk({nm, "_data"}, dev.output_data_to_dev, 0);
    endtask

    task automatic run_word(input bit d_sw, input bit o_sw, input bit neg, input bit st,
                            input int al, input int cl, input bit spur,
                            input int abort_at, input bit dbl, input bit rst_mid);
        int n, io0, s0, p0, rise0, r;
        bit dm, done, dbl_done;
        dm = d_sw & ~o_sw;
        n = dm ? 9 : 10;
        for (int i = 0; i < 16; i++) digs[i] = dm ? dec_tab[i] : oct_tab[i];
        @(negedge clk);
        didx = 0; ack_lat = al; ac_lat = cl; spur_pend = spur;
        dec = d_sw; oct = o_sw; sign = neg; stp = st;
        expq.delete();
        expq.push_back(neg ? 5'b00011 : 5'b00010);
        for (int i = 0; i < n; i++) expq.push_back(5'b10000 | {1'b0, dm ? digs[i] : (digs[i] & 4'h7)});
        expq.push_back(5'b00111);
        exp_dec = dm;
        io0 = io_cnt; s0 = start_cnt; p0 = stop_cnt; rise0 = vld_rise; wbase = got.size();
        done = 0; dbl_done = 0;
        order = 1'b1;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            r = vld_rise - rise0;
            if (dbl && !dbl_done && r == 2) begin
                order = 1'b1;
                dbl_done = 1;
            end else order = 1'b0;
            if (abort_at >= 0 && r >= abort_at + 1 && dev.output_vld_to_dev) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_vld", dev.output_vld_to_dev, 0);
                chk("abort_active", active, 0);
                repeat (6) @(negedge clk);
                chk("abort_no_start", start_cnt - s0, 0);
                chk("abort_no_stop", stop_cnt - p0, 0);
                expq.delete();
                done = 1;
            end else if (rst_mid && shifting && r >= 3) begin
                resetn = 1'b0;
                @(negedge clk);
                outs_zero("rst_mid");
                resetn = 1'b1;
                repeat (3) @(negedge clk);
                chk("rst_no_start", start_cnt - s0, 0);
                expq.delete();
                done = 1;
            end else if (start_cnt != s0 || stop_cnt != p0) begin
                @(negedge clk);
                chk("order_io_count", io_cnt - io0, n);
                chk("start_count", start_cnt - s0, st ? 0 : 1);
                chk("stop_count", stop_cnt - p0, st ? 1 : 0);
                chk("active_after", active, 0);
                chk("queue_empty", expq.size(), 0);
                done = 1;
            end
        end
        order = 1'b0;
        spur_pend = 0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: word not finished, %0d chars left", expq.size());
            expq.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        outs_zero("reset");
        resetn = 1'b1;
        @(negedge clk);

        run_word(0, 1, 0, 0, 2, 1, 0, -1, 0, 0);
        chk("lit_sign_pos", got[wbase], 5'b00010);
        chk("lit_d0_masked", got[wbase + 1], 5'b10111);
        chk("lit_d1", got[wbase + 2], 5'b10000);
        chk("lit_end", got[wbase + 11], 5'b00111);

        run_word(0, 0, 0, 0, 1, 2, 0, -1, 0, 0);
        run_word(1, 0, 1, 0, 2, 1, 0, -1, 0, 0);
        chk("lit_sign_neg", got[wbase], 5'b00011);
        chk("lit_dec_d0", got[wbase + 1], 5'b11001);
        chk("lit_dec_end", got[wbase + 10], 5'b00111);

        run_word(1, 1, 1, 1, 2, 1, 0, -1, 0, 0);
        run_word(0, 1, 1, 0, 3, 20, 1, -1, 0, 0);
        run_word(0, 1, 0, 0, 5, 1, 0, 3, 0, 0);
        run_word(1, 0, 0, 0, 2, 1, 0, -1, 0, 0);
        chk("lit_restart_sign", got[wbase], 5'b00010);
        run_word(0, 1, 0, 0, 2, 3, 0, -1, 1, 0);
        run_word(1, 0, 1, 0, 2, 4, 0, -1, 0, 1);
        run_word(0, 1, 0, 0, 1, 1, 0, -1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
